// File: rtl/delay_link_pkg.sv
// Shared definitions for the AWG delay-load link (host TX and future RX checker).
// Holds frame constants, field widths, the request record, frame packer and TX FSM states.
package delay_link_pkg;

  localparam logic [7:0]  OPCODE     = 8'h02;
  localparam logic [11:0] TAG        = 12'h002;
  localparam int          ADDR_W     = 11;
  localparam int          DELAY_W    = 24;
  localparam int          GA_W       = 4;
  localparam int          PORT_W     = 4;
  localparam int          REQ_PORT_W = 2;
  localparam int          REQ_W      = REQ_PORT_W + ADDR_W + DELAY_W;

  typedef struct packed {
    logic [REQ_PORT_W-1:0] port;
    logic [ADDR_W-1:0]     addr;
    logic [DELAY_W-1:0]    delay;
  } delay_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } tx_state_e;

  // Port index 0..3 travels on the wire as 1..4.
  function automatic logic [63:0] pack_frame(
    input delay_req_t      req,
    input logic [GA_W-1:0] ga
  );
    logic [PORT_W-1:0] code;
    code = {2'b00, req.port} + 4'd1;
    return {OPCODE, TAG, 1'b0, req.addr, ga, code, req.delay};
  endfunction

endpackage

// File: rtl/delay_cmd_fifo.sv
// Synchronous request FIFO, DEPTH x REQ_W ({port, addr, delay}).
// Ports: clk, rst_n, wr_en/wr_data, rd_en/rd_data, full, empty, level.
module delay_cmd_fifo
  import delay_link_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [REQ_W-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [REQ_W-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_wr, do_rd;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    level_d  = level_q + LW'(do_wr) - LW'(do_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/delay_frame_tx.sv
// Host-side delay-frame encoder: buffers delay-write requests and hands
// 64-bit frames one at a time to UART_TX_DATA.
// Ports: I_clk_10M, I_rst_n, I_GA, I_req_* / O_req_ready (request side),
// O_data / O_data_valid / I_tx_ready (UART side), O_busy, O_fifo_level,
// O_frame_cnt, O_err_timeout.
// Optional watchdog on the UART handshake: define DELAY_TX_TIMEOUT_EN.
module delay_frame_tx
  import delay_link_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                        I_clk_10M,
  input  logic                        I_rst_n,
  input  logic [3:0]                  I_GA,
  input  logic                        I_req_valid,
  output logic                        O_req_ready,
  input  logic [1:0]                  I_req_port,
  input  logic [10:0]                 I_req_addr,
  input  logic [23:0]                 I_req_delay,
  output logic [63:0]                 O_data,
  output logic                        O_data_valid,
  input  logic                        I_tx_ready,
  output logic                        O_busy,
  output logic [$clog2(FIFO_DEPTH):0] O_fifo_level,
  output logic [15:0]                 O_frame_cnt,
  output logic                        O_err_timeout
);

  localparam int GW       = 16;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam tx_state_e AFTER_WAIT =
    (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  tx_state_e        state_q, state_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [63:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             rdy_en_q;
  logic             fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [REQ_W-1:0] fifo_head;
  delay_req_t       wr_req;

  assign wr_req = '{port: I_req_port, addr: I_req_addr, delay: I_req_delay};

  // rdy_en_q keeps the request side closed while in reset and
  // opens it on the first clock after release.
  assign O_req_ready = rdy_en_q & ~fifo_full;

  delay_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (I_clk_10M),
    .rst_n   (I_rst_n),
    .wr_en   (I_req_valid & O_req_ready),
    .wr_data (wr_req),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (O_fifo_level)
  );

`ifdef DELAY_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
  assign O_err_timeout = err_q;
`else
  assign O_err_timeout = 1'b0;
`endif

  // The frame is registered on the IDLE->LOAD edge so O_data_valid
  // is high exactly during LOAD; the head entry is popped in LOAD.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && I_tx_ready) begin
          state_d     = ST_LOAD;
          data_d      = pack_frame(delay_req_t'(fifo_head), I_GA);
          valid_d     = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!I_tx_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (I_tx_ready) begin
          state_d   = AFTER_WAIT;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_LAST)) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef DELAY_TX_TIMEOUT_EN
    // One counter spans both wait states; expiry abandons the frame.
    tmo_cnt_d = '0;
    err_d     = err_q;
    if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (tmo_cnt_q == TMO_LAST) begin
        state_d   = AFTER_WAIT;
        gap_cnt_d = '0;
        err_d     = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_cnt_q <= frame_cnt_d;
      rdy_en_q    <= 1'b1;
    end
  end

`ifdef DELAY_TX_TIMEOUT_EN
  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
`endif

  assign O_data       = data_q;
  assign O_data_valid = valid_q;
  assign O_frame_cnt  = frame_cnt_q;
  assign O_busy       = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_delay_frame_tx.sv
// Self-checking bench for delay_frame_tx: vector table, scoreboard of
// expected frames, UART tx-ready model and multi-cycle corner sequences.
module tb_delay_frame_tx;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 2048;
  localparam int BUSY  = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ga;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_port;
  logic [10:0] req_addr;
  logic [23:0] req_delay;
  logic [63:0] data;
  logic        data_valid;
  logic        tx_ready;
  logic        busy;
  logic [3:0]  level;
  logic [15:0] frame_cnt;
  logic        err_tmo;

  bit   auto_md;
  logic man_rdy;
  logic mdl_rdy;
  int   busy_cnt;
  bit   drop_pend;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   last_pulse = -1;
  bit   prev_valid = 1'b0;
  logic [63:0] sb [$];

  typedef struct {
    logic [1:0]  port;
    logic [10:0] addr;
    logic [23:0] delay;
    logic [63:0] frame;
  } vec_t;

  vec_t tbl [5];

  assign tx_ready = auto_md ? mdl_rdy : man_rdy;

  always #5 clk = ~clk;

  delay_frame_tx #(
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .I_clk_10M     (clk),
    .I_rst_n       (rst_n),
    .I_GA          (ga),
    .I_req_valid   (req_valid),
    .O_req_ready   (req_ready),
    .I_req_port    (req_port),
    .I_req_addr    (req_addr),
    .I_req_delay   (req_delay),
    .O_data        (data),
    .O_data_valid  (data_valid),
    .I_tx_ready    (tx_ready),
    .O_busy        (busy),
    .O_fifo_level  (level),
    .O_frame_cnt   (frame_cnt),
    .O_err_timeout (err_tmo)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [1:0] p,
      input logic [10:0] a, input logic [23:0] d);
    logic [3:0] code;
    code = {2'b00, p} + 4'd1;
    return {8'h02, 12'h002, 1'b0, a, 4'hE, code, d};
  endfunction

  // One clock: advance to the falling edge, update the UART model,
  // then check any frame the DUT is presenting.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (drop_pend) begin
      mdl_rdy   = 1'b0;
      busy_cnt  = BUSY;
      drop_pend = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) mdl_rdy = 1'b1;
    end
    if (data_valid) begin
      check("single_pulse", 64'(prev_valid), 64'd0);
      if (last_pulse >= 0)
        check("spacing", 64'(cyc - last_pulse >= BUSY + GAP), 64'd1);
      last_pulse = cyc;
      pulses++;
      drop_pend = auto_md;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got %h want none", data);
      end else begin
        check("frame", data, sb.pop_front());
      end
    end
    prev_valid = data_valid;
  endtask

  // Holds the request until accepted, bounded.
  task automatic send(input logic [1:0] p, input logic [10:0] a,
                      input logic [23:0] d, input logic [63:0] exp);
    int n;
    req_valid = 1'b1;
    req_port  = p;
    req_addr  = a;
    req_delay = d;
    n = 0;
    while (!req_ready && n < 3000) begin
      tick();
      n++;
    end
    check("req_accept", 64'(req_ready), 64'd1);
    if (req_ready) sb.push_back(exp);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || sb.size() != 0 || busy_cnt != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_sb", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_valid"}, 64'(data_valid), 64'd0);
    check({tag, "_data"}, data, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_level"}, 64'(level), 64'd0);
    check({tag, "_cnt"}, 64'(frame_cnt), 64'd0);
    check({tag, "_err"}, 64'(err_tmo), 64'd0);
  endtask

  initial begin
    int p0;
    int n;
    tbl[0] = '{2'd0, 11'd0, 24'd10, 64'h02002000e100000a};
    tbl[1] = '{2'd1, 11'd0, 24'd20, 64'h02002000e2000014};
    tbl[2] = '{2'd2, 11'd0, 24'd30, 64'h02002000e300001e};
    tbl[3] = '{2'd3, 11'd0, 24'd40, 64'h02002000e4000028};
    tbl[4] = '{2'd2, 11'h7FF, 24'hFFFFFF, 64'h020027FFe3FFFFFF};

    auto_md   = 1'b1;
    mdl_rdy   = 1'b1;
    man_rdy   = 1'b0;
    busy_cnt  = 0;
    drop_pend = 1'b0;
    ga        = 4'hE;
    req_valid = 1'b0;
    req_port  = '0;
    req_addr  = '0;
    req_delay = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;

    // Reset state and ready release
    repeat (3) tick();
    check_zero("rst");
    rst_n = 1'b1;
    #1 check("ready_pre_clk", 64'(req_ready), 64'd0);
    tick();
    check("ready_after_rst", 64'(req_ready), 64'd1);

    // Four ports in order, with latency into an idle link
    p0 = pulses;
    send(tbl[0].port, tbl[0].addr, tbl[0].delay, tbl[0].frame);
    send(tbl[1].port, tbl[1].addr, tbl[1].delay, tbl[1].frame);
    check("latency", 64'(pulses - p0), 64'd1);
    for (int i = 2; i < 4; i++)
      send(tbl[i].port, tbl[i].addr, tbl[i].delay, tbl[i].frame);
    wait_idle(2000);
    check("four_pulses", 64'(pulses - p0), 64'd4);
    check("frame_cnt4", 64'(frame_cnt), 64'd4);

    // Maximum field values
    send(tbl[4].port, tbl[4].addr, tbl[4].delay, tbl[4].frame);
    wait_idle(500);
    check("frame_cnt5", 64'(frame_cnt), 64'd5);
    check("hold_data", data, 64'h020027FFe3FFFFFF);

    // Burst of nine into a stalled link
    auto_md = 1'b0;
    man_rdy = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 8; i++)
      send(2'(i), 11'(i * 3 + 1), 24'(100 + i),
           exp_frame(2'(i), 11'(i * 3 + 1), 24'(100 + i)));
    check("full_ready", 64'(req_ready), 64'd0);
    check("level8", 64'(level), 64'd8);
    req_valid = 1'b1;
    req_port  = 2'd3;
    req_addr  = 11'h123;
    req_delay = 24'hABCDEF;
    repeat (3) tick();
    check("full_drop", 64'(level), 64'd8);
    check("stall_no_pulse", 64'(pulses - p0), 64'd0);
    auto_md  = 1'b1;
    mdl_rdy  = 1'b1;
    busy_cnt = 0;
    send(2'd3, 11'h123, 24'hABCDEF,
         exp_frame(2'd3, 11'h123, 24'hABCDEF));
    check("ninth_after_load", 64'(pulses - p0), 64'd1);
    wait_idle(2000);
    check("burst_pulses", 64'(pulses - p0), 64'd9);
    check("frame_cnt14", 64'(frame_cnt), 64'd14);

    // Request while the transmitter is not ready
    auto_md = 1'b0;
    man_rdy = 1'b0;
    p0 = pulses;
    send(2'd1, 11'h055, 24'h000777,
         exp_frame(2'd1, 11'h055, 24'h000777));
    repeat (10) tick();
    check("held_no_pulse", 64'(pulses - p0), 64'd0);
    check("held_level", 64'(level), 64'd1);
    auto_md  = 1'b1;
    mdl_rdy  = 1'b1;
    busy_cnt = 0;
    wait_idle(500);
    check("held_one_pulse", 64'(pulses - p0), 64'd1);

    // Reset while waiting for the transmitter, three still queued
    p0 = pulses;
    for (int i = 0; i < 4; i++)
      send(2'(i), 11'(i), 24'(i),
           exp_frame(2'(i), 11'(i), 24'(i)));
    repeat (10) tick();
    check("pre_rst_level", 64'(level), 64'd3);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (300) tick();
    check("post_rst_pulses", 64'(pulses - p0), 64'd1);
    check("post_rst_cnt", 64'(frame_cnt), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

`ifdef DELAY_TX_TIMEOUT_EN
    // Transmitter stuck after a load
    auto_md = 1'b0;
    man_rdy = 1'b1;
    p0 = pulses;
    send(2'd0, 11'h010, 24'h000100,
         exp_frame(2'd0, 11'h010, 24'h000100));
    send(2'd1, 11'h020, 24'h000200,
         exp_frame(2'd1, 11'h020, 24'h000200));
    man_rdy = 1'b0;
    n = 0;
    while (!err_tmo && n < TMO + 100) begin
      tick();
      n++;
    end
    check("err_set", 64'(err_tmo), 64'd1);
    check("tmo_time", 64'(n >= TMO && n <= TMO + 2), 64'd1);
    auto_md  = 1'b1;
    mdl_rdy  = 1'b1;
    busy_cnt = 0;
    wait_idle(1000);
    check("tmo_next_sent", 64'(pulses - p0), 64'd2);
    check("err_sticky", 64'(err_tmo), 64'd1);
`else
    n = 0;
    check("err_tied0", 64'(err_tmo), 64'(n));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
